// File: rtl/seq_detect_ctrl.sv
// Word-level sequencer for the external 1011 detector: accepts a word, flushes the detector,
// shifts the word out MSB-first and reports a saturating match count. Option: SEQDET_CTRL_FIRSTPOS_EN.
module seq_detect_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             det_bit,
    output logic             det_reset,
    input  logic             det_seen,
    output logic [CNT_W-1:0] match_count,
    output logic             match_valid,
    output logic             busy
`ifdef SEQDET_CTRL_FIRSTPOS_EN
    ,
    output logic [POS_W-1:0] first_pos
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [POS_W-1:0] LAST_K = POS_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [POS_W-1:0] bit_k;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sample;

    // det_seen is registered in the detector, so it lags det_bit by one cycle:
    // SHIFT cycle k reports bit k-1, and DRAIN reports the final bit.
    always_comb begin
        sample = det_seen && (((state == SHIFT) && (bit_k != '0)) || (state == DRAIN));
    end

    always_comb begin
        cnt_next = cnt;
        if (sample && (cnt != '1)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        det_bit    = (state == SHIFT) && sreg[WIDTH-1];
        det_reset  = reset || (state == FLUSH);
        busy       = (state != IDLE);
        word_ready = (state == IDLE);
    end

`ifdef SEQDET_CTRL_FIRSTPOS_EN
    logic             found;
    logic [POS_W-1:0] fpos_work;
    logic [POS_W-1:0] hit_pos;

    always_comb begin
        hit_pos = (state == DRAIN) ? LAST_K : (bit_k - POS_W'(1));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_k       <= '0;
            cnt         <= '0;
            match_count <= '0;
            match_valid <= 1'b0;
`ifdef SEQDET_CTRL_FIRSTPOS_EN
            found       <= 1'b0;
            fpos_work   <= '0;
            first_pos   <= '0;
`endif
        end else begin
            match_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        sreg  <= word_in;
                        bit_k <= '0;
                        cnt   <= '0;
`ifdef SEQDET_CTRL_FIRSTPOS_EN
                        found     <= 1'b0;
                        fpos_work <= '0;
`endif
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    cnt  <= cnt_next;
`ifdef SEQDET_CTRL_FIRSTPOS_EN
                    if (sample && !found) begin
                        found     <= 1'b1;
                        fpos_work <= hit_pos;
                    end
`endif
                    if (bit_k == LAST_K) begin
                        state <= DRAIN;
                    end else begin
                        bit_k <= bit_k + POS_W'(1);
                    end
                end
                DRAIN: begin
                    match_count <= cnt_next;
                    match_valid <= 1'b1;
`ifdef SEQDET_CTRL_FIRSTPOS_EN
                    if (found) begin
                        first_pos <= fpos_work;
                    end else if (sample) begin
                        first_pos <= hit_pos;
                    end else begin
                        first_pos <= '0;
                    end
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

- Word-level controller that sequences the 1011 sequence detector (`seq_detect_1011`).
- Accepts a parallel word over a valid/ready handshake, flushes the detector, and serialises the word MSB-first into it, one bit per cycle.
- Samples the detector's registered `seq_seen` and reports a saturating per-word match count.
- Sits between the word-oriented stimulus/bus side and the bit-serial detector; the detector is instantiated outside this block.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; must be ≥ 4.
- `CNT_W`, 4: width of the match counter.
- `POS_W`, `$clog2(WIDTH)`: width of the first-match position (used only with the macro).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `word_in`  in  WIDTH  word to scan; bit WIDTH-1 is sent first.
- `word_valid`  in  1  `word_in` valid.
- `word_ready`  out  1  controller can accept a word.
- `det_bit`  out  1  drives the detector's `inp_bit`.
- `det_reset`  out  1  drives the detector's `reset`.
- `det_seen`  in  1  the detector's `seq_seen`.
- `match_count`  out  CNT_W  matches found in the last completed word.
- `match_valid`  out  1  one-cycle pulse: `match_count` updated.
- `busy`  out  1  a word is in flight.
- `first_pos`  out  POS_W  present only with `SEQDET_CTRL_FIRSTPOS_EN`.

## Operation
FSM states:
- **IDLE**
  - `word_ready`=1.
  - On `word_valid` && `word_ready`: load the shift register with `word_in`, clear the bit counter and match counter, go to FLUSH.
- **FLUSH** (1 cycle)
  - `det_reset`=1; go to SHIFT.
- **SHIFT** (WIDTH cycles, k = 0..WIDTH-1)
  - `det_bit` = shift register MSB; shift left each cycle.
  - For k ≥ 1, if `det_seen`=1, increment the match counter.
  - After k = WIDTH-1, go to DRAIN.
- **DRAIN** (1 cycle)
  - Sample `det_seen` once more; this reflects the last bit.
  - Go to IDLE.
  - Register `match_valid`=1 for the next cycle and copy the counter into `match_count`.

Datapath and output rules:
- `det_seen` is not sampled in SHIFT cycle 0: it reflects the flushed detector.
- `match_count` saturates at 2^CNT_W-1 and holds its value until the next `match_valid`.
- `det_bit`=0 in every state except SHIFT.
- `det_reset` = `reset` OR (state==FLUSH).
- `busy` = (state != IDLE).
- `word_ready` = (state == IDLE).

Reset values:
- State IDLE.
- `match_count`=0, `match_valid`=0, `det_bit`=0, `busy`=0.
- `word_ready`=1 from the first cycle after `reset` deasserts.
- `det_reset`=1 while `reset`=1.

## Timing
- Accept in cycle T.
- FLUSH in T+1.
- SHIFT in T+2..T+WIDTH+1.
- DRAIN in T+WIDTH+2.
- `match_valid` pulse in T+WIDTH+3. The FSM is back in IDLE in that cycle, so a word presented then is accepted; throughput is one word per WIDTH+3 cycles.
- A match completed by bit k is counted in cycle T+k+3 (the detector output is registered).
- `word_valid` outside IDLE is ignored; the producer holds the word until `word_ready`.
- `reset` mid-word: the FSM returns to IDLE next cycle, the counter clears, `match_count` is 0, no `match_valid` is issued, and the detector is reset via `det_reset`.

## Configuration
- `SEQDET_CTRL_FIRSTPOS_EN` defined:
  - Port `first_pos` exists.
  - Records the index k (0 = MSB) of the bit that completed the first match in the word.
  - Updated together with `match_count`.
  - Reset value 0.
  - 0 when `match_count`=0.
- Not defined: port `first_pos` and its register are absent; all other behaviour is identical.

## Test plan
- Reset held 3 cycles → `det_reset`=1, `match_count`=0, `match_valid`=0, `busy`=0; after release, `word_ready`=1.
- `word_in`=8'b1011_1011 → `match_valid` at T+11, `match_count`=2, `first_pos`=3 (if enabled).
- `word_in`=8'h00, then 8'hFF → two `match_valid` pulses, each with `match_count`=0.
- `word_in`=8'b0101_1010, with the next word offered in the `match_valid` cycle → first result `match_count`=1, `first_pos`=4 (if enabled); the next word is accepted in that same cycle.
- CNT_W=1, WIDTH=8, `word_in`=8'b1011_1011 → `match_count` saturates at 1.
- `reset` asserted in SHIFT cycle 3 → IDLE next cycle, no `match_valid`; a following 8'b1011_0000 gives `match_count`=1.
